// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : lsu_defs
// Shared funct3/mode constants, FSM encoding and width helpers for lsu_ctrl.
// Revision: 1.0
// ============================================================================
package lsu_defs;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One-hot width code understood by the RAM byte-write-enable decoder
  localparam logic [2:0] MODE_NONE = 3'b000;
  localparam logic [2:0] MODE_B    = 3'b001;
  localparam logic [2:0] MODE_H    = 3'b010;
  localparam logic [2:0] MODE_W    = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic [2:0] f3_mode(input logic [1:0] sz);
    case (sz)
      2'b00:   f3_mode = MODE_B;
      2'b01:   f3_mode = MODE_H;
      2'b10:   f3_mode = MODE_W;
      default: f3_mode = MODE_NONE;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      f3_legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
    else
      f3_legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   replicate = {4{d[7:0]}};
      2'b01:   replicate = {2{d[15:0]}};
      default: replicate = d;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_load_align
// Lane select and sign/zero extension of a RAM read word for loads.
// Revision: 1.0
// ============================================================================
module lsu_load_align
  import lsu_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  cs,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sext;

  assign sext = ~funct3[2];

  always_comb begin
    byte_lane = rdata[7:0];
    case (cs)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = cs[1] ? rdata[31:16] : rdata[15:0];

    case (funct3[1:0])
      2'b00:   data = {{24{sext & byte_lane[7]}}, byte_lane};
      2'b01:   data = {{16{sext & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_ctrl
// Single-outstanding load/store controller feeding the RAM write-enable
// decoder. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word.
// Revision: 1.0
// ============================================================================
module lsu_ctrl
  import lsu_defs::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [2:0]        ram_mode,
  output logic [1:0]        ram_cs,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  state_t      state, state_nx;
  logic [2:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic        legal, trap, go, accept;
  logic [1:0]  cs_al;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  assign legal  = f3_legal(req_we, req_funct3);
  assign accept = req_valid & req_ready;
  assign go     = legal & ~trap;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign cs_al = req_addr[1:0];
`else
  assign trap = 1'b0;
  // Misaligned half/word accesses are silently aligned down
  always_comb begin
    case (req_funct3[1:0])
      2'b01:   cs_al = {req_addr[1], 1'b0};
      2'b10:   cs_al = 2'b00;
      default: cs_al = req_addr[1:0];
    endcase
  end
`endif

  lsu_load_align u_align (
    .funct3 (f3_q),
    .cs     (ram_cs),
    .rdata  (ram_rdata),
    .data   (load_data)
  );

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    ram_en    = 1'b0;
    ram_mode  = MODE_NONE;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = go ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        ram_en = 1'b1;
        if (we_q) begin
          ram_mode = f3_mode(f3_q[1:0]);
          state_nx = S_RESP;
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 3'd1) state_nx = S_RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      we_q      <= 1'b0;
      f3_q      <= 3'd0;
      ram_addr  <= '0;
      ram_cs    <= 2'd0;
      ram_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            rsp_rdata <= 32'd0;
            rsp_err   <= ~go;
            if (go) begin
              ram_addr  <= req_addr[ADDR_W+1:2];
              ram_cs    <= cs_al;
              ram_wdata <= replicate(req_funct3[1:0], req_wdata);
            end
          end
        end
        S_ISSUE: cnt <= 3'(RD_LAT);
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) rsp_rdata <= load_data;
        end
        default: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_ctrl
// Table-driven self-checking bench for lsu_ctrl (RD_LAT=1 and RD_LAT=3 copies).
// Revision: 1.0
// ============================================================================
module tb_lsu_ctrl;

  localparam int ADDR_W = 12;
  localparam int LAT    = 1;
  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        req_valid, valid3, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, ram_rdata;

  logic              req_ready, ram_en, rsp_valid, rsp_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_mode;
  logic [1:0]        ram_cs;
  logic [31:0]       ram_wdata, rsp_rdata;

  logic              req_ready3, ram_en3, rsp_valid3, rsp_err3;
  logic [ADDR_W-1:0] ram_addr3;
  logic [2:0]        ram_mode3;
  logic [1:0]        ram_cs3;
  logic [31:0]       ram_wdata3, rsp_rdata3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_mode(ram_mode), .ram_cs(ram_cs), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  lsu_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .ram_en(ram_en3), .ram_addr(ram_addr3),
    .ram_mode(ram_mode3), .ram_cs(ram_cs3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        issue;
    logic        err;
    logic [2:0]  mode;
    logic [1:0]  cs;
    logic [11:0] waddr;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic issue, input logic err, input logic [2:0] mode,
                              input logic [1:0] cs, input logic [11:0] waddr,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.issue = issue; v.err = err; v.mode = mode; v.cs = cs; v.waddr = waddr;
    v.exp_wd = exp_wd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    int exp_lat;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata; ram_rdata = GARB;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    if (v.issue) begin
      chk($sformatf("v%0d_en", idx), {31'd0, ram_en}, 32'd1);
      chk($sformatf("v%0d_mode", idx), {29'd0, ram_mode}, {29'd0, v.mode});
      chk($sformatf("v%0d_cs", idx), {30'd0, ram_cs}, {30'd0, v.cs});
      chk($sformatf("v%0d_addr", idx), {20'd0, ram_addr}, {20'd0, v.waddr});
      if (v.we) chk($sformatf("v%0d_wdata", idx), ram_wdata, v.exp_wd);
    end else begin
      chk($sformatf("v%0d_noen", idx), {28'd0, ram_en, ram_mode}, 32'd0);
    end
    while (!rsp_valid && cyc < 12) begin
      if (cyc > 1) chk($sformatf("v%0d_idle_en", idx), {28'd0, ram_en, ram_mode}, 32'd0);
      @(negedge clk);
      cyc++;
      ram_rdata = (cyc == LAT + 1) ? v.rdata : GARB;
    end
    exp_lat = !v.issue ? 1 : (v.we ? 2 : LAT + 2);
    chk($sformatf("v%0d_lat", idx), cyc, exp_lat);
    chk($sformatf("v%0d_valid", idx), {31'd0, rsp_valid}, 32'd1);
    chk($sformatf("v%0d_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rd);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_drop", idx), {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b1; rst3 = 1'b1;
    req_valid = 1'b0; valid3 = 1'b0; req_we = 1'b0; rsp_ready = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0; ram_rdata = 32'd0;

    vecs[0]  = mk(1, 3'b000, 32'h6,    32'hA5,       0,            1, 0, 3'b001, 2'b10, 12'h1,   32'hA5A5A5A5, 0);
    vecs[1]  = mk(1, 3'b001, 32'h10A,  32'h1234BEEF, 0,            1, 0, 3'b010, 2'b10, 12'h42,  32'hBEEFBEEF, 0);
    vecs[2]  = mk(1, 3'b010, 32'h2FFC, 32'hCAFEF00D, 0,            1, 0, 3'b100, 2'b00, 12'hBFF, 32'hCAFEF00D, 0);
    vecs[3]  = mk(0, 3'b000, 32'h3,    0, 32'h80112233,            1, 0, 3'b000, 2'b11, 12'h0,   0, 32'hFFFFFF80);
    vecs[4]  = mk(0, 3'b100, 32'h3,    0, 32'h80112233,            1, 0, 3'b000, 2'b11, 12'h0,   0, 32'h00000080);
    vecs[5]  = mk(0, 3'b101, 32'h2,    0, 32'h80112233,            1, 0, 3'b000, 2'b10, 12'h0,   0, 32'h00008011);
    vecs[6]  = mk(0, 3'b001, 32'h20,   0, 32'h1234F00D,            1, 0, 3'b000, 2'b00, 12'h8,   0, 32'hFFFFF00D);
    vecs[7]  = mk(0, 3'b010, 32'h44,   0, 32'h89ABCDEF,            1, 0, 3'b000, 2'b00, 12'h11,  0, 32'h89ABCDEF);
    vecs[8]  = mk(0, 3'b000, 32'h1,    0, 32'h80112233,            1, 0, 3'b000, 2'b01, 12'h0,   0, 32'h00000022);
    vecs[9]  = mk(0, 3'b011, 32'h8,    0, 32'h12345678,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
    vecs[10] = mk(0, 3'b110, 32'h8,    0, 32'h12345678,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
    vecs[11] = mk(1, 3'b100, 32'h8,    32'hFF,       0,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
    vecs[12] = mk(1, 3'b011, 32'h8,    32'hFF,       0,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[13] = mk(1, 3'b001, 32'h1,    32'hABCD,     0,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
    vecs[14] = mk(0, 3'b010, 32'h46,   0, 32'h89ABCDEF,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
    vecs[15] = mk(0, 3'b001, 32'h3,    0, 32'h80112233,            0, 1, 3'b000, 2'b00, 12'h0,   0, 0);
`else
    vecs[13] = mk(1, 3'b001, 32'h1,    32'hABCD,     0,            1, 0, 3'b010, 2'b00, 12'h0,   32'hABCDABCD, 0);
    vecs[14] = mk(0, 3'b010, 32'h46,   0, 32'h89ABCDEF,            1, 0, 3'b000, 2'b00, 12'h11,  0, 32'h89ABCDEF);
    vecs[15] = mk(0, 3'b001, 32'h3,    0, 32'h80112233,            1, 0, 3'b000, 2'b10, 12'h0,   0, 32'hFFFF8011);
`endif

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outs", {27'd0, rsp_valid, rsp_err, ram_en, ram_cs}, 32'd0);
    chk("rst_mode_addr", {17'd0, ram_mode, ram_addr}, 32'd0);
    chk("rst_data", ram_wdata | rsp_rdata, 32'd0);
    rst = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Back-pressure: response held, new request must wait for IDLE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h6; req_wdata = 32'hA5;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_ready_en", k), {30'd0, req_ready, ram_en}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_reaccept_en", {31'd0, ram_en}, 32'd1);
    cyc = 0;
    while (!rsp_valid && cyc < 10) begin @(negedge clk); cyc++; end
    chk("bp_second_rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // RD_LAT=3 copy: full load latency with data present only in its window
    @(negedge clk);
    valid3 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; ram_rdata = GARB;
    @(negedge clk);
    valid3 = 1'b0;
    cyc = 1;
    chk("l3_en", {31'd0, ram_en3}, 32'd1);
    while (!rsp_valid3 && cyc < 12) begin
      @(negedge clk);
      cyc++;
      ram_rdata = (cyc == 4) ? 32'h13579BDF : GARB;
    end
    chk("l3_lat", cyc, 5);
    chk("l3_rdata", rsp_rdata3, 32'h13579BDF);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during WAIT aborts the load
    valid3 = 1'b1;
    @(negedge clk);
    valid3 = 1'b0;
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("abort_state", {28'd0, rsp_valid3, ram_en3, req_ready3, rsp_err3}, 32'd2);
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", {31'd0, rsp_valid3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
